// File: rtl/stopwatch_button_cond_if.sv
// Button conditioner signal bundle: raw pad input plus the conditioned level and event pulses.
// The slave modport is the conditioner; the master modport is whatever consumes its outputs.
interface stopwatch_button_cond_if;
  logic btn_raw;
  logic btn_level;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;

  modport master (
    output btn_raw,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  long_pulse
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output long_pulse
  );
endinterface

// File: rtl/stopwatch_button_cond.sv
// Synchronises and debounces one push-button, then emits the level, press/release pulses
// and a one-shot long-press pulse for the stopwatch control FSMs.
module stopwatch_button_cond #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 200_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  stopwatch_button_cond_if.slave  btn
);

  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned LG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LG_W-1:0] LG_LAST = LG_W'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  state_t                 state_q, state_d;
  logic [DB_W-1:0]        db_q, db_d;
  logic [LG_W-1:0]        lg_q, lg_d;
  logic                   done_q, done_d;
  logic                   long_fire;
  logic                   level_q, press_q, release_q, long_q;

  // Input synchroniser; the pad is asynchronous to clk.
  always_ff @(posedge clk) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], btn.btn_raw};
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      db_q    <= '0;
      lg_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      db_q    <= db_d;
      lg_q    <= lg_d;
      done_q  <= done_d;
    end
  end

  // Long counting runs on every HELD cycle, including the one that starts a release,
  // so a terminal count reached on that cycle still fires in the first RELEASE_WAIT cycle.
  always_comb begin
    state_d   = state_q;
    db_d      = db_q;
    lg_d      = lg_q;
    done_d    = done_q;
    long_fire = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_WAIT;
          db_d    = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
        end else if (db_q == DB_LAST) begin
          state_d = HELD;
          lg_d    = '0;
          done_d  = 1'b0;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          db_d    = '0;
        end
        if (!done_q) begin
          if (lg_q == LG_LAST) begin
            done_d    = 1'b1;
            long_fire = 1'b1;
          end else begin
            lg_d = lg_q + LG_W'(1);
          end
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          state_d = IDLE;
        end else begin
          db_d = db_q + DB_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registered outputs derived from the upcoming state transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      level_q   <= (state_d == HELD) || (state_d == RELEASE_WAIT);
      press_q   <= (state_q == PRESS_WAIT) && (state_d == HELD);
      release_q <= (state_q == RELEASE_WAIT) && (state_d == IDLE);
      long_q    <= long_fire;
    end
  end

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.long_pulse    = long_q;

endmodule
